seq_det_sched: RTL

//  Sequences a single-bit serial sequence detector (inputs B, Rst; output w) from a word-level stream.

---
 rtl/seq_det_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - word-to-serial scheduler for an external bit-serial sequence detector
//
// Purpose:
//   Accepts parallel words over a valid/ready handshake, shifts each word MSB-first
//   into an external single-bit sequence detector, counts the detector's w=1
//   responses for that word and returns one result per word over a second
//   valid/ready handshake. The detector is cleared before and after every word
//   so each word is scored independently.
//
// Ports:
//   Clk        in   1       clock, all state on posedge
//   Rst        in   1       synchronous active-high reset
//   in_valid   in   1       word request valid
//   in_ready   out  1       scheduler can accept a word (IDLE only)
//   in_word    in   WORD_W  bits to send, bit WORD_W-1 first
//   in_len     in   LEN_W   bits to send (1..WORD_W); 0 or >WORD_W means WORD_W
//   det_B      out  1       serial bit to the detector
//   det_Rst    out  1       detector reset (Rst, INIT or DRAIN)
//   det_w      in   1       detector match output
//   res_valid  out  1       result valid (REPORT)
//   res_ready  in   1       result consumer ready
//   res_count  out  CNT_W   saturating count of credited w=1 samples
//   res_first  out  LEN_W   bit index of the first credited w=1, 0 if none
//   res_hit    out  1       res_count != 0
//   busy       out  1       word in flight (SHIFT or DRAIN)

module seq_det_sched #(
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4,
  parameter int DET_LAT = 1,
  parameter int LEN_W   = $clog2(WORD_W + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [LEN_W-1:0]  in_len,
  output logic              det_B,
  output logic              det_Rst,
  input  logic              det_w,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic [LEN_W-1:0]  res_first,
  output logic              res_hit,
  output logic              busy
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SHIFT,
    DRAIN,
    REPORT
  } state_t;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t              state;
  state_t              state_nx;

  logic [WORD_W-1:0]   shreg;
  logic [LEN_W-1:0]    eff_len;
  logic [LEN_W-1:0]    idx;
  logic [CNT_W-1:0]    count;
  logic [LEN_W-1:0]    first;
  logic                first_seen;

  logic                accept;
  logic                last_bit;
  logic                sample_en;
  logic [LEN_W-1:0]    sample_idx;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= INIT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    det_B     = 1'b0;
    // Rst reaches the detector combinationally so it is cleared on the same edge.
    det_Rst   = Rst;
    case (state)
      INIT: begin
        det_Rst  = 1'b1;
        state_nx = IDLE;
      end
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        det_B = shreg[WORD_W-1];
        if (last_bit) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // Last response of a Moore detector is still visible here; the reset
        // only takes effect at the end of this cycle.
        busy     = 1'b1;
        det_Rst  = 1'b1;
        state_nx = REPORT;
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = INIT;
      end
    endcase
  end

  assign accept   = (state == IDLE) && in_valid;
  assign last_bit = (idx == (eff_len - LEN_W'(1)));

  // ---------------------------------------------------------------------------
  // Response sampling: which cycles carry a detector response and which bit
  // it belongs to depends on the detector's latency.
  // ---------------------------------------------------------------------------
  always_comb begin
    sample_en  = 1'b0;
    sample_idx = '0;
    if (DET_LAT != 0) begin
      // Moore: w reflects the bit sent one cycle earlier.
      if ((state == SHIFT) && (idx != '0)) begin
        sample_en  = 1'b1;
        sample_idx = idx - LEN_W'(1);
      end else if (state == DRAIN) begin
        sample_en  = 1'b1;
        sample_idx = eff_len - LEN_W'(1);
      end
    end else begin
      // Mealy: w reflects the bit being sent this cycle.
      if (state == SHIFT) begin
        sample_en  = 1'b1;
        sample_idx = idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shreg      <= '0;
      eff_len    <= '0;
      idx        <= '0;
      count      <= '0;
      first      <= '0;
      first_seen <= 1'b0;
    end else if (accept) begin
      shreg      <= in_word;
      eff_len    <= ((in_len == '0) || (in_len > FULL_LEN)) ? FULL_LEN : in_len;
      idx        <= '0;
      count      <= '0;
      first      <= '0;
      first_seen <= 1'b0;
    end else begin
      if (state == SHIFT) begin
        shreg <= shreg << 1;
        idx   <= idx + LEN_W'(1);
      end
      if (sample_en && det_w) begin
        if (count != CNT_MAX) begin
          count <= count + CNT_W'(1);
        end
        if (!first_seen) begin
          first      <= sample_idx;
          first_seen <= 1'b1;
        end
      end
    end
  end

  // Result registers are only rewritten at accept or during SHIFT/DRAIN, so
  // they hold steady for the whole REPORT state.
  assign res_count = count;
  assign res_first = first;
  assign res_hit   = (count != '0);

endmodule
